// File: rtl/obi_mem_responder.sv
// OBI-style memory responder: word-addressed memory behind a req/gnt/rvalid port with
// programmable grant stall, response latency and outstanding-request depth.
module obi_mem_responder #(
   parameter int unsigned Depth          = 1024,
   parameter logic [31:0] AddrBase       = 32'h0,
   parameter int unsigned GntDelay       = 0,
   parameter int unsigned RspLatency     = 1,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        gnt_o,
   input  logic [31:0] addr_i,
   input  logic        we_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic        rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   localparam int unsigned IdxW    = $clog2(Depth);
   localparam int unsigned PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned OccW    = $clog2(MaxOutstanding + 1);
   localparam logic [31:0] WinMask = ~((Depth * 4) - 1);

   if (Depth < 4 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $fatal(1, "obi_mem_responder: Depth must be a power of 2 >= 4");
   end
   if ((AddrBase & ~WinMask) != 32'h0) begin : g_bad_base
      $fatal(1, "obi_mem_responder: AddrBase must be aligned to Depth*4");
   end
   if (GntDelay > 15) begin : g_bad_gnt
      $fatal(1, "obi_mem_responder: GntDelay out of range 0..15");
   end
   if (RspLatency < 1 || RspLatency > 15) begin : g_bad_lat
      $fatal(1, "obi_mem_responder: RspLatency out of range 1..15");
   end
   if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_bad_out
      $fatal(1, "obi_mem_responder: MaxOutstanding out of range 1..8");
   end

   logic [31:0]               mem_q [Depth];
   logic [3:0]                scnt_q, scnt_d;
   logic [OccW-1:0]           occ_q, occ_d;
   logic [PtrW-1:0]           head_q, head_d, tail_q, tail_d;
   logic [MaxOutstanding-1:0] vld_q, vld_d;
   logic [MaxOutstanding-1:0] err_q, err_d;
   logic [3:0]                cnt_q [MaxOutstanding];
   logic [3:0]                cnt_d [MaxOutstanding];
   logic [31:0]               dat_q [MaxOutstanding];
   logic [31:0]               dat_d [MaxOutstanding];

   logic            hit, push, pop;
   logic [IdxW-1:0] idx;
   logic [1:0]      unused_addr;

   assign unused_addr = addr_i[1:0];
   assign hit         = (addr_i & WinMask) == AddrBase;
   assign idx         = addr_i[IdxW+1:2];

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
   endfunction

   // Occupancy is the pre-pop count, so a slot freed by this cycle's response is not reusable yet.
   always_comb begin
      gnt_o = req_i && (scnt_q == 4'(GntDelay)) && (occ_q < OccW'(MaxOutstanding));
      push  = gnt_o;
      pop   = vld_q[head_q] && (cnt_q[head_q] == 4'd0);
   end

   always_comb begin
      scnt_d = scnt_q;
      if (!req_i || gnt_o) begin
         scnt_d = '0;
      end else if (scnt_q != 4'(GntDelay)) begin
         scnt_d = scnt_q + 4'd1;
      end
   end

   always_comb begin
      vld_d  = vld_q;
      err_d  = err_q;
      cnt_d  = cnt_q;
      dat_d  = dat_q;
      head_d = head_q;
      tail_d = tail_q;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
         if (vld_q[i] && cnt_q[i] != 4'd0) begin
            cnt_d[i] = cnt_q[i] - 4'd1;
         end
      end
      if (pop) begin
         vld_d[head_q] = 1'b0;
         head_d        = ptr_inc(head_q);
      end
      if (push) begin
         vld_d[tail_q] = 1'b1;
         cnt_d[tail_q] = 4'(RspLatency - 1);
         dat_d[tail_q] = (we_i || !hit) ? '0 : mem_q[idx];
         err_d[tail_q] = !hit;
         tail_d        = ptr_inc(tail_q);
      end
      occ_d = occ_q + OccW'(push) - OccW'(pop);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         scnt_q <= '0;
         occ_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         vld_q  <= '0;
      end else begin
         scnt_q <= scnt_d;
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
         vld_q  <= vld_d;
      end
   end

   always_ff @(posedge clk_i) begin
      err_q <= err_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
   end

   // Memory survives reset; only accepts outside reset may modify it.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push && we_i && hit) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be_i[b]) begin
               mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rvalid_o = pop;
   assign rdata_o  = pop ? dat_q[head_q] : '0;
   assign err_o    = pop & err_q[head_q];

   a_no_empty_pop: assert property (@(posedge clk_i) disable iff (!rst_ni)
      rvalid_o |-> (occ_q != '0));
   a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      occ_q <= OccW'(MaxOutstanding));

endmodule

// File: tb/tb_obi_mem_responder.sv
// Scoreboard bench for obi_mem_responder: three instances cover zero/non-zero grant
// stall and short/long response latency; a monitor pops expected responses per rvalid.
module tb_obi_mem_responder;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req    [NI];
   logic        we     [NI];
   logic [31:0] addr   [NI];
   logic [3:0]  be     [NI];
   logic [31:0] wdata  [NI];
   logic        gnt    [NI];
   logic        rvalid [NI];
   logic [31:0] rdata  [NI];
   logic        err    [NI];

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int          inst;
      int          cyc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t expq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   obi_mem_responder #(.Depth(1024), .AddrBase(32'h0), .GntDelay(0), .RspLatency(1),
                       .MaxOutstanding(2)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
      .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]),
      .rdata_o(rdata[0]), .err_o(err[0]));

   obi_mem_responder #(.Depth(1024), .AddrBase(32'h0), .GntDelay(3), .RspLatency(1),
                       .MaxOutstanding(2)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
      .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]),
      .rdata_o(rdata[1]), .err_o(err[1]));

   obi_mem_responder #(.Depth(1024), .AddrBase(32'h0), .GntDelay(0), .RspLatency(4),
                       .MaxOutstanding(2)) u2 (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req[2]), .gnt_o(gnt[2]), .addr_i(addr[2]),
      .we_i(we[2]), .be_i(be[2]), .wdata_i(wdata[2]), .rvalid_o(rvalid[2]),
      .rdata_o(rdata[2]), .err_o(err[2]));

   function automatic int lat_of(input int inst);
      return (inst == 2) ? 4 : 1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; holds req until granted, then registers the expected response.
   task automatic xfer(input int inst, input bit w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input bit track, input logic [31:0] exp_rd,
                       input bit exp_err, output int acc);
      exp_t e;
      acc = -1;
      req[inst] = 1'b1; we[inst] = w; addr[inst] = a; be[inst] = b; wdata[inst] = d;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         if (gnt[inst]) begin
            acc = cyc;
            if (track) begin
               e.inst = inst; e.cyc = cyc + lat_of(inst); e.rdata = exp_rd; e.err = exp_err;
               expq.push_back(e);
            end
            break;
         end
         @(posedge clk);
         #1;
      end
      if (acc < 0) begin
         checks++;
         failures++;
         $display("FAIL xfer_timeout inst=%0d addr=%h got=no_gnt exp=gnt", inst, a);
      end
      @(posedge clk);
      #1;
      req[inst] = 1'b0;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rvalid[i]) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL rsp_unexpected inst=%0d cyc=%0d got rdata=%h err=%b exp=none",
                        i, cyc, rdata[i], err[i]);
            end else begin
               exp_t e;
               e = expq.pop_front();
               checks++;
               if (e.inst != i || e.cyc != cyc || rdata[i] !== e.rdata || err[i] !== e.err) begin
                  failures++;
                  $display("FAIL rsp got inst=%0d cyc=%0d rdata=%h err=%b exp inst=%0d cyc=%0d rdata=%h err=%b",
                           i, cyc, rdata[i], err[i], e.inst, e.cyc, e.rdata, e.err);
               end
            end
         end else begin
            checks++;
            if (rdata[i] !== 32'h0 || err[i] !== 1'b0) begin
               failures++;
               $display("FAIL idle_outputs inst=%0d cyc=%0d got rdata=%h err=%b exp rdata=0 err=0",
                        i, cyc, rdata[i], err[i]);
            end
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int start;
      int acc;
      for (int i = 0; i < NI; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; be[i] = '0; wdata[i] = '0;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset_gnt%0d", i), 32'(gnt[i]), 32'd0);
         chk($sformatf("reset_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
      end
      @(posedge clk);
      #1;

      // 1: write then read, zero stall, latency 1
      start = cyc;
      xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, acc);
      chk("t1_wr_gnt_cycle", 32'(acc - start), 32'd0);
      start = cyc;
      xfer(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, acc);
      chk("t1_rd_gnt_cycle", 32'(acc - start), 32'd0);

      // 2: partial byte-enable write
      xfer(0, 1'b1, 32'h20, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, acc);
      xfer(0, 1'b1, 32'h20, 4'b0101, 32'h11223344, 1'b1, 32'h0, 1'b0, acc);
      xfer(0, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 32'hFF22FF44, 1'b0, acc);

      // 3: grant stall of 3, and restart after an early drop
      idle(2);
      start = cyc;
      xfer(1, 1'b1, 32'h80, 4'hF, 32'h00000001, 1'b1, 32'h0, 1'b0, acc);
      chk("t3_gnt_after_3", 32'(acc - start), 32'd3);
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h84; be[1] = 4'hF; wdata[1] = 32'h2;
      @(negedge clk);
      chk("t3_no_gnt_before_drop", 32'(gnt[1]), 32'd0);
      @(posedge clk);
      #1;
      req[1] = 1'b0;
      @(negedge clk);
      chk("t3_no_gnt_dropped", 32'(gnt[1]), 32'd0);
      @(posedge clk);
      #1;
      start = cyc;
      xfer(1, 1'b1, 32'h84, 4'hF, 32'h00000002, 1'b1, 32'h0, 1'b0, acc);
      chk("t3_restart_gnt_after_3", 32'(acc - start), 32'd3);
      start = cyc;
      xfer(1, 1'b0, 32'h84, 4'h0, 32'h0, 1'b1, 32'h00000002, 1'b0, acc);
      chk("t3_rd_gnt_after_3", 32'(acc - start), 32'd3);

      // 4: outstanding limit 2 with latency 4
      xfer(2, 1'b1, 32'h100, 4'hF, 32'hA0A0A0A0, 1'b1, 32'h0, 1'b0, acc);
      xfer(2, 1'b1, 32'h104, 4'hF, 32'hA1A1A1A1, 1'b1, 32'h0, 1'b0, acc);
      xfer(2, 1'b1, 32'h108, 4'hF, 32'hA2A2A2A2, 1'b1, 32'h0, 1'b0, acc);
      idle(6);
      start = cyc;
      xfer(2, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 32'hA0A0A0A0, 1'b0, acc);
      chk("t4_accept0", 32'(acc - start), 32'd0);
      xfer(2, 1'b0, 32'h104, 4'h0, 32'h0, 1'b1, 32'hA1A1A1A1, 1'b0, acc);
      chk("t4_accept1", 32'(acc - start), 32'd1);
      xfer(2, 1'b0, 32'h108, 4'h0, 32'h0, 1'b1, 32'hA2A2A2A2, 1'b0, acc);
      chk("t4_accept2", 32'(acc - start), 32'd5);
      idle(6);

      // 5: out-of-window accesses and the in-range alias
      xfer(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, acc);
      xfer(0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 1'b1, 32'h0, 1'b1, acc);
      xfer(0, 1'b0, 32'h1000, 4'h0, 32'h0, 1'b1, 32'h0, 1'b1, acc);
      xfer(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hCAFEF00D, 1'b0, acc);

      // 6: reset discards outstanding responses, memory kept
      xfer(2, 1'b1, 32'h40, 4'hF, 32'hA5A50001, 1'b1, 32'h0, 1'b0, acc);
      idle(6);
      xfer(2, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
      xfer(2, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(8);
      start = cyc;
      xfer(2, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hA5A50001, 1'b0, acc);
      chk("t6_post_reset_gnt", 32'(acc - start), 32'd0);

      idle(8);
      chk("queue_empty", 32'(expq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
